pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter unit for the single-cycle/multi-cycle CPU datapath; successor to the basic PC register.
//  Holds the fetch PC and selects the next PC from sequential, branch, jump, call/return and trap sources, honouring a busy stall.
//  Includes a DEPTH-entry return-address stack (RAS) and misaligned-target detection.
//  Sits between decode/ALU (redirect requests) and instruction memory (pc output).
// PARAMETERS
//  XLEN      32            PC / address width in bits
//  STEP      4             byte increment per sequential instruction (power of 2)
//  RESET_VEC 32'h0000_0000 PC value held in reset and used for the first fetch
//  TRAP_VEC  32'h0000_0100 PC loaded on trap or misaligned redirect
//  DEPTH     4             RAS entries (>=2)
// PORTS
//  CLK           in   1     clock; all updates on posedge
//  RESET         in   1     asynchronous, active-high reset
//  busy          in   1     stall: hold pc and RAS (trap still serviced)
//  trap          in   1     redirect to TRAP_VEC
//  branch_taken  in   1     conditional branch resolved taken
//  branch_target in   XLEN  branch destination
//  jump          in   1     unconditional jump to jump_target
//  call          in   1     jump to jump_target and push pc+STEP to RAS
//  ret           in   1     return: pop RAS top to pc
//  jump_target   in   XLEN  target for jump/call; fallback target for ret on empty RAS
//  pc            out  XLEN  current fetch address (registered)
//  pc_plus_step  out  XLEN  pc+STEP, combinational, modulo 2^XLEN
//  ras_empty     out  1     RAS holds 0 entries
//  ras_full      out  1     RAS holds DEPTH entries
//  misalign_err  out  1     registered 1-cycle pulse: rejected misaligned target
//  ras_underflow out  1     registered 1-cycle pulse: ret on empty RAS
// BEHAVIOUR
//  - Reset: pc=RESET_VEC (not RESET_VEC-STEP), RAS count=0, ras_empty=1, ras_full=0, pulses=0. First posedge after release advances to RESET_VEC+STEP.
//  - Posedge priority (first match wins):
//    1 trap                 -> pc=TRAP_VEC; RAS untouched; applies even if busy.
//    2 busy                 -> pc, RAS held; all other requests ignored (caller re-presents them).
//    3 ret                  -> if RAS non-empty pc=top, pop; else pc=jump_target, ras_underflow=1. Simultaneous call ignored.
//    4 call                 -> pc=jump_target; push pc+STEP.
//    5 jump                 -> pc=jump_target.
//    6 branch_taken         -> pc=branch_target.
//    7 otherwise            -> pc=pc+STEP (wraps 2^XLEN-STEP -> 0).
//  - Alignment: a chosen target with addr mod STEP != 0 is rejected: pc=TRAP_VEC, misalign_err=1 next cycle.
//    On a rejected call, no push. On a rejected ret, the pop still occurs.
//  - RAS: LIFO, circular storage. A push when full overwrites the oldest entry, and the count stays DEPTH.
//    RAS entries are not cleared on trap.
//  - Pulse outputs are high for exactly one cycle after the triggering edge; otherwise 0 (also 0 while busy).
//  - Reset asserted mid-operation: outputs take their reset values immediately, independent of CLK.
//  - Latency: a redirect requested before edge N appears on pc after edge N; there are no delay slots.
// TESTING
//  1 Reset held, then released, with 3 idle clocks -> pc 0x0 during reset, then 0x4, 0x8, 0xC.
//  2 pc=0x20, busy=1 for 2 clocks with jump=1, target 0x80 -> pc stays 0x20. Release busy with jump still high -> pc=0x80.
//  3 Calls at pc 0x10->0x100, 0x104->0x200, then ret twice -> pc 0x100, 0x200, 0x108, 0x14. ras_empty=1 at end.
//  4 DEPTH+1 calls, then DEPTH+1 rets with jump_target=0x300 -> first DEPTH returns are the newest entries, in LIFO order.
//    The oldest entry is lost. The last ret gives pc=0x300, with ras_underflow pulsing once.
//  5 branch_taken with target 0x42 -> pc=TRAP_VEC (0x100), misalign_err high for one cycle.
//    trap asserted with busy=1 -> pc=0x100.
//  6 pc=0xFFFF_FFFC, idle clock -> pc=0x0. Async RESET pulse between clock edges -> pc=0x0 without a clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter unit for the CPU datapath. Holds the fetch PC and picks
// the next PC each clock from trap, return, call, jump, branch or sequential
// sources, honouring a busy stall. A DEPTH-entry circular return-address
// stack (RAS) backs call/ret, and misaligned redirect targets are diverted
// to TRAP_VEC with a one-cycle error pulse.
//
// Ports
//   CLK            clock, all state updates on posedge
//   RESET          asynchronous, active-high reset
//   busy           stall: pc and RAS hold (trap is still serviced)
//   trap           redirect to TRAP_VEC
//   branch_taken   redirect to branch_target
//   branch_target  branch destination
//   jump           redirect to jump_target
//   call           redirect to jump_target and push pc+STEP
//   ret            pop RAS top into pc (jump_target if RAS is empty)
//   jump_target    jump/call target, fallback target for ret on empty RAS
//   pc             current fetch address (registered)
//   pc_plus_step   pc+STEP, combinational, modulo 2^XLEN
//   ras_empty      RAS holds no entries
//   ras_full       RAS holds DEPTH entries
//   misalign_err   one-cycle pulse: a misaligned target was rejected
//   ras_underflow  one-cycle pulse: ret was issued on an empty RAS

module pc_sequencer #(
  parameter int              XLEN      = 32,
  parameter int              STEP      = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
  parameter int              DEPTH     = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            busy,
  input  logic            trap,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic            call,
  input  logic            ret,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_step,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misalign_err,
  output logic            ras_underflow
);

  localparam int              PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW         = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
  localparam logic [PW-1:0]   LAST_IDX   = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL_CNT   = CW'(DEPTH);

  logic [XLEN-1:0] ras_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   ras_cnt;

  logic [PW-1:0]   ptr_inc;
  logic [PW-1:0]   ptr_dec;
  logic [XLEN-1:0] ras_top;

  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] target;
  logic            want_push;
  logic            do_push;
  logic            do_pop;
  logic            next_mis;
  logic            next_uf;

  assign pc_plus_step = pc + STEP_V;
  assign ras_empty    = (ras_cnt == '0);
  assign ras_full     = (ras_cnt == FULL_CNT);

  // wr_ptr always points at the slot the next push writes. Because the
  // storage is circular, a push while full lands on the oldest entry.
  always_comb begin
    ptr_inc = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PW'(1);
    ptr_dec = (wr_ptr == '0) ? LAST_IDX : wr_ptr - PW'(1);
    ras_top = ras_mem[ptr_dec];
  end

  // Next-PC selection. Trap wins even over busy. Otherwise one target is
  // chosen by priority and then validated for alignment; a misaligned target
  // diverts to TRAP_VEC and suppresses a call's push, but a ret's pop has
  // already consumed the entry and still happens.
  always_comb begin
    next_pc   = pc;
    target    = pc_plus_step;
    want_push = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    next_mis  = 1'b0;
    next_uf   = 1'b0;
    if (trap) begin
      next_pc = TRAP_VEC;
    end else if (!busy) begin
      if (ret) begin
        if (!ras_empty) begin
          target = ras_top;
          do_pop = 1'b1;
        end else begin
          target  = jump_target;
          next_uf = 1'b1;
        end
      end else if (call) begin
        target    = jump_target;
        want_push = 1'b1;
      end else if (jump) begin
        target = jump_target;
      end else if (branch_taken) begin
        target = branch_target;
      end
      if ((target & ALIGN_MASK) != '0) begin
        next_pc  = TRAP_VEC;
        next_mis = 1'b1;
      end else begin
        next_pc = target;
        do_push = want_push;
      end
    end
  end

  // PC, pulse outputs and RAS state. The count saturates at DEPTH on an
  // overwriting push so ras_full stays asserted.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc            <= RESET_VEC;
      misalign_err  <= 1'b0;
      ras_underflow <= 1'b0;
      wr_ptr        <= '0;
      ras_cnt       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ras_mem[i] <= '0;
      end
    end else begin
      pc            <= next_pc;
      misalign_err  <= next_mis;
      ras_underflow <= next_uf;
      if (do_push) begin
        ras_mem[wr_ptr] <= pc_plus_step;
        wr_ptr          <= ptr_inc;
        if (ras_cnt != FULL_CNT) begin
          ras_cnt <= ras_cnt + CW'(1);
        end
      end else if (do_pop) begin
        wr_ptr  <= ptr_dec;
        ras_cnt <= ras_cnt - CW'(1);
      end
    end
  end

endmodule
